// File: rtl/video_irq_pkg.sv
// Shared constants for the video interrupt controller: register map, source limits
// and the VECTOR layout.
package video_irq_pkg;

  localparam int unsigned MAX_SRC       = 16;
  localparam int unsigned VEC_VALID_BIT = 15;

  localparam logic [2:0] ADDR_STATUS    = 3'd0;
  localparam logic [2:0] ADDR_PENDING   = 3'd1;
  localparam logic [2:0] ADDR_MASK      = 3'd2;
  localparam logic [2:0] ADDR_VECTOR    = 3'd3;
  localparam logic [2:0] ADDR_IRQ_COUNT = 3'd4;
  localparam logic [2:0] ADDR_CONTROL   = 3'd5;

endpackage

// File: rtl/video_irq_prio_enc.sv
// Lowest-index-first priority encoder over the active interrupt vector.
module video_irq_prio_enc #(
  parameter int unsigned NUM_SRC = 8
) (
  input  logic [NUM_SRC-1:0] active,
  output logic               valid,
  output logic [3:0]         index
);

  always_comb begin
    valid = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (active[i] && !valid) begin
        valid = 1'b1;
        index = 4'(i);
      end
    end
  end

endmodule

// File: rtl/video_irq_ctrl.sv
// Avalon-MM interrupt controller: edge/level source capture, mask, global enable,
// priority vector and a saturating count of CPU interrupt assertions.
module video_irq_ctrl
  import video_irq_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 8,
  parameter logic [15:0] SRC_EDGE = 16'h00FF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_SRC-1:0] irq_src,
  input  logic [2:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [15:0]        writedata,
  output logic [15:0]        readdata,
  output logic               irq
);

  localparam logic [NUM_SRC-1:0] EDGE_MASK = SRC_EDGE[NUM_SRC-1:0];

  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;
  logic [NUM_SRC-1:0] active;
  logic [NUM_SRC-1:0] wr_bits;
  logic [NUM_SRC-1:0] w1c;
  logic [NUM_SRC-1:0] w1s;
  logic [NUM_SRC-1:0] pend_nxt;
  logic               ctrl_en;
  logic [15:0]        irq_count;
  logic               vld;
  logic [3:0]         idx;
  logic               wr_en;
  logic               irq_nxt;
  logic [15:0]        rd_nxt;
  logic [15:0]        pend_ext;
  logic [15:0]        act_ext;
  logic [15:0]        mask_ext;
  logic [15:0]        vec;
  logic               unused_wd;

  assign wr_en     = chipselect && !write_n;
  assign wr_bits   = writedata[NUM_SRC-1:0];
  assign unused_wd = ^writedata;
  assign active    = pending & mask;
  assign irq_nxt   = ctrl_en && (|active);

  video_irq_prio_enc #(.NUM_SRC(NUM_SRC)) u_prio (
    .active (active),
    .valid  (vld),
    .index  (idx)
  );

  // W1C only masks the old pending state, so a same-cycle edge or W1S still sets.
  always_comb begin
    w1c      = (wr_en && address == ADDR_STATUS)  ? wr_bits : '0;
    w1s      = (wr_en && address == ADDR_PENDING) ? wr_bits : '0;
    pend_nxt = (irq_src & ~EDGE_MASK)
             | (EDGE_MASK & ((pending & ~w1c) | w1s | (irq_src & ~src_d)));
  end

  always_comb begin
    pend_ext = '0;
    act_ext  = '0;
    mask_ext = '0;
    vec      = '0;
    pend_ext[NUM_SRC-1:0] = pending;
    act_ext[NUM_SRC-1:0]  = active;
    mask_ext[NUM_SRC-1:0] = mask;
    vec[VEC_VALID_BIT]    = vld;
    vec[3:0]              = idx;
    case (address)
      ADDR_STATUS:    rd_nxt = act_ext;
      ADDR_PENDING:   rd_nxt = pend_ext;
      ADDR_MASK:      rd_nxt = mask_ext;
      ADDR_VECTOR:    rd_nxt = vec;
      ADDR_IRQ_COUNT: rd_nxt = irq_count;
      ADDR_CONTROL:   rd_nxt = {15'b0, ctrl_en};
      default:        rd_nxt = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_d     <= '0;
      pending   <= '0;
      mask      <= '0;
      ctrl_en   <= 1'b0;
      irq_count <= '0;
      irq       <= 1'b0;
      readdata  <= '0;
    end else begin
      src_d    <= irq_src;
      pending  <= pend_nxt;
      irq      <= irq_nxt;
      readdata <= rd_nxt;
      if (wr_en && address == ADDR_MASK)
        mask <= wr_bits;
      if (wr_en && address == ADDR_CONTROL)
        ctrl_en <= writedata[0];
      if (wr_en && address == ADDR_IRQ_COUNT)
        irq_count <= '0;
      else if (irq_nxt && !irq && irq_count != '1)
        irq_count <= irq_count + 16'd1;
    end
  end

endmodule

// File: doc/video_irq_ctrl.md
VIDEO_IRQ_CTRL -- requirements
Module: video_irq_ctrl

Interface
REQ-001 SHALL have parameter NUM_SRC, default 8, number of interrupt sources (legal range 1..16).
REQ-002 SHALL have parameter SRC_EDGE, default 16'h00FF, per-source sensitivity (1 = rising-edge latched, 0 = level).
REQ-003 clk  input  1  sole clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 irq_src  input  NUM_SRC  source requests (timer irq on bit 0), synchronous to clk.
REQ-006 address  input  3  Avalon-MM word address.
REQ-007 chipselect  input  1  slave select.
REQ-008 write_n  input  1  active-low write strobe.
REQ-009 writedata  input  16  write data.
REQ-010 readdata  output  16  registered read data.
REQ-011 irq  output  1  aggregated interrupt to CPU, registered.

Function
REQ-012 Register map SHALL be: 0 STATUS (R: pending&mask; W: write-1-to-clear pending), 1 PENDING (R: raw pending; W: write-1-to-set), 2 MASK (RW), 3 VECTOR (R), 4 IRQ_COUNT (R; any write clears), 5 CONTROL (RW, bit0 = global enable), 6-7 read 0, writes ignored.
REQ-013 Write strobe SHALL be chipselect && ~write_n && address match; reads SHALL have no side effects.
REQ-014 readdata SHALL be registered every cycle from the address mux: one-cycle read latency, independent of chipselect; bits above NUM_SRC read 0.
REQ-015 Edge sources: pending bit SHALL set in the cycle after irq_src & ~src_d (src_d = irq_src delayed one clk), stay set until cleared by STATUS W1C.
REQ-016 Level sources: pending bit SHALL equal irq_src delayed one clk; W1C and W1S SHALL have no effect on them.
REQ-017 PENDING W1S SHALL set edge-source pending bits written as 1.
REQ-018 Same-cycle rising edge and W1C on one edge source: set SHALL win (no event lost).
REQ-019 active = pending & MASK; irq SHALL be registered: irq <= CONTROL[0] && |active, i.e. one cycle after pending/mask/enable change.
REQ-020 VECTOR SHALL read {valid, 11'b0, index[3:0]}: valid = |active, index = lowest-numbered active bit; 16'h0000 when none active.
REQ-021 IRQ_COUNT SHALL increment on each 0->1 transition of irq, saturate at 16'hFFFF; write to address 4 clears to 0, clear wins over same-cycle increment.
REQ-022 MASK write SHALL update only bits [NUM_SRC-1:0]; CONTROL write only bit 0.

Reset
REQ-023 On reset SHALL clear: pending, src_d, MASK, CONTROL, IRQ_COUNT, readdata=16'h0000, irq=0.
REQ-024 Source already high when reset deasserts SHALL be treated as a rising edge (src_d reset to 0) and latch pending on the next cycle.
REQ-025 Reset asserted mid-operation SHALL discard all pending events; no irq in the cycle after reset release.

Structure
REQ-026 Shared package SHALL hold register address constants (ADDR_STATUS..ADDR_CONTROL), MAX_SRC=16 and VECTOR valid bit position.
REQ-027 Priority encoder (lowest-index-first, NUM_SRC in, valid+4-bit index out) SHALL be a sub-module named video_irq_prio_enc; all else in the top.

Verification
REQ-028 MASK=1, CONTROL=1, pulse irq_src[0] one cycle -> STATUS=16'h0001, irq high 2 cycles after pulse, VECTOR=16'h8000, IRQ_COUNT=1; write STATUS 16'h0001 -> irq low next+1 cycle.
REQ-029 Edges on src[2] and src[5] same cycle, MASK=16'h0024 -> VECTOR=16'h8002; W1C 16'h0004 -> VECTOR=16'h8005.
REQ-030 Rising edge on src[3] in same cycle as W1C 16'h0008 -> PENDING bit 3 remains 1.
REQ-031 SRC_EDGE=16'h007F, hold src[7] high, MASK=16'h0080, CONTROL=1 -> irq high; W1C 16'h0080 -> no change; drop src[7] -> irq low within 2 cycles.
REQ-032 CONTROL=0 with pending active -> irq stays 0, IRQ_COUNT unchanged; CONTROL=1 -> irq rises, count increments by exactly 1.
REQ-033 Force IRQ_COUNT to 16'hFFFF via 65535 toggles (or backdoor) then one more irq edge -> stays 16'hFFFF; write address 4 -> 16'h0000; reset mid-pending -> all registers read 0.
